axi_stream_adder: RTL and testbench

//  Joins two AXI-Stream operand channels (A, B), adds one operand pair per

---
 rtl/axi_adder_defs.sv | 29 ++
 rtl/axis_hold_slot.sv | 51 +++++
 rtl/axi_stream_adder.sv | 91 +++++++++
 tb/tb_axi_stream_adder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_adder_defs.sv
// Shared widths and operand extension helper for the stream adder and its neighbours.
// Pure definitions: no latency, no flow control.
package axi_adder_defs;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 16;
    // Widest operand/sum the ext() helper supports.
    localparam int EXT_W     = 32;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Extends the low in_w bits of x to EXT_W bits, by sign or by zero.
    function automatic logic [EXT_W-1:0] ext(
        input logic [EXT_W-1:0] x,
        input int               in_w,
        input logic             is_signed
    );
        logic [EXT_W-1:0] mask;
        mask = (in_w >= EXT_W) ? '1 : ((EXT_W'(1) << in_w) - EXT_W'(1));
        if (is_signed && (in_w > 0) && x[$clog2(EXT_W)'(in_w - 1)]) begin
            return x | ~mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/axis_hold_slot.sv
// One-entry operand holding register with full flag; ready is purely registered state.
// Captures on valid&ready, empties when the join consumes it; refuses new data while full.
module axis_hold_slot
    import axi_adder_defs::*;
#(
    parameter int W = IN_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         take_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign in_ready_o = (state_q == SLOT_EMPTY) && !rst;
    assign load       = in_valid_i && in_ready_o;
    assign full_o     = (state_q == SLOT_FULL);
    assign data_o     = data_q;

    // A full slot cannot load, so load and take never coincide.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = in_data_i;
        end else if (take_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/axi_stream_adder.sv
// Joins operand streams A and B and emits the extended sum on a registered AXI-Stream output.
// Sum valid one edge after both operands are held; a stalled output blocks the join and so the slots.
module axi_stream_adder
    import axi_adder_defs::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_a_data,
    input  logic             s_axis_a_valid,
    output logic             s_axis_a_ready,
    input  logic [IN_W-1:0]  s_axis_b_data,
    input  logic             s_axis_b_valid,
    output logic             s_axis_b_ready,
    output logic [OUT_W-1:0] m_axis_data,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic [15:0]      pair_count
);

    logic             a_full, b_full;
    logic [IN_W-1:0]  a_dat, b_dat;
    logic             join_w, beat_w;
    logic [OUT_W-1:0] sum_w;

    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [15:0]      cnt_q, cnt_d;

    axis_hold_slot #(.W(IN_W)) u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (s_axis_a_data),
        .in_valid_i (s_axis_a_valid),
        .in_ready_o (s_axis_a_ready),
        .take_i     (join_w),
        .full_o     (a_full),
        .data_o     (a_dat)
    );

    axis_hold_slot #(.W(IN_W)) u_slot_b (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (s_axis_b_data),
        .in_valid_i (s_axis_b_valid),
        .in_ready_o (s_axis_b_ready),
        .take_i     (join_w),
        .full_o     (b_full),
        .data_o     (b_dat)
    );

    assign beat_w = m_valid_q && m_axis_ready;
    // The output register is free if empty or being drained this very edge.
    assign join_w = a_full && b_full && (!m_valid_q || m_axis_ready);
    assign sum_w  = OUT_W'(ext(EXT_W'(a_dat), IN_W, SIGNED) + ext(EXT_W'(b_dat), IN_W, SIGNED));

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;
        if (join_w) begin
            m_valid_d = 1'b1;
            m_data_d  = sum_w;
        end else if (beat_w) begin
            m_valid_d = 1'b0;
        end
        if (beat_w) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign pair_count   = cnt_q;

endmodule

// File: tb/tb_axi_stream_adder.sv
// Bench for axi_stream_adder: unsigned and signed instances share stimulus and are checked
// every cycle against a queue-based transaction model, plus hand-computed directed results.
module tb_axi_stream_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, m_ready;

    logic        a_rdy_u, b_rdy_u, m_vld_u;
    logic [15:0] m_dat_u, cnt_u;
    logic        a_rdy_s, b_rdy_s, m_vld_s;
    logic [15:0] m_dat_s, cnt_s;

    axi_stream_adder #(.IN_W(8), .OUT_W(16), .SIGNED(1'b0)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_a_data  (a_data),
        .s_axis_a_valid (a_valid),
        .s_axis_a_ready (a_rdy_u),
        .s_axis_b_data  (b_data),
        .s_axis_b_valid (b_valid),
        .s_axis_b_ready (b_rdy_u),
        .m_axis_data    (m_dat_u),
        .m_axis_valid   (m_vld_u),
        .m_axis_ready   (m_ready),
        .pair_count     (cnt_u)
    );

    axi_stream_adder #(.IN_W(8), .OUT_W(16), .SIGNED(1'b1)) u_dut_s (
        .clk            (clk),
        .rst            (rst),
        .s_axis_a_data  (a_data),
        .s_axis_a_valid (a_valid),
        .s_axis_a_ready (a_rdy_s),
        .s_axis_b_data  (b_data),
        .s_axis_b_valid (b_valid),
        .s_axis_b_ready (b_rdy_s),
        .m_axis_data    (m_dat_s),
        .m_axis_valid   (m_vld_s),
        .m_axis_ready   (m_ready),
        .pair_count     (cnt_s)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: pending operands per side, sums awaiting acceptance, accepted count.
    logic [7:0]  pa[$], pb[$];
    logic [15:0] ou[$], os[$];
    logic [15:0] mcnt;
    logic [7:0]  mx, my;
    bit          m_fire, m_join, m_aacc, m_bacc;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                pa.delete(); pb.delete(); ou.delete(); os.delete();
                mcnt = 16'd0;
            end else begin
                m_aacc = a_valid && (pa.size() == 0);
                m_bacc = b_valid && (pb.size() == 0);
                m_fire = (ou.size() != 0) && m_ready;
                m_join = (pa.size() != 0) && (pb.size() != 0) && ((ou.size() == 0) || m_ready);
                if (m_fire) begin
                    void'(ou.pop_front());
                    void'(os.pop_front());
                    mcnt = mcnt + 16'd1;
                end
                if (m_join) begin
                    mx = pa.pop_front();
                    my = pb.pop_front();
                    ou.push_back(16'(mx) + 16'(my));
                    os.push_back({{8{mx[7]}}, mx} + {{8{my[7]}}, my});
                end
                if (m_aacc) pa.push_back(a_data);
                if (m_bacc) pb.push_back(b_data);
            end
        end
    end

    bit e_ar, e_br, e_v;
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_ar = !rst && (pa.size() == 0);
            e_br = !rst && (pb.size() == 0);
            e_v  = (ou.size() != 0);
            chk("a_ready_u", 32'(a_rdy_u), 32'(e_ar));
            chk("b_ready_u", 32'(b_rdy_u), 32'(e_br));
            chk("a_ready_s", 32'(a_rdy_s), 32'(e_ar));
            chk("b_ready_s", 32'(b_rdy_s), 32'(e_br));
            chk("m_valid_u", 32'(m_vld_u), 32'(e_v));
            chk("m_valid_s", 32'(m_vld_s), 32'(e_v));
            chk("count_u", 32'(cnt_u), 32'(mcnt));
            chk("count_s", 32'(cnt_s), 32'(mcnt));
            if (e_v) begin
                chk("m_data_u", 32'(m_dat_u), 32'(ou[0]));
                chk("m_data_s", 32'(m_dat_s), 32'(os[0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_a(input logic [7:0] d);
        bit ok = 1'b0;
        a_data  = d;
        a_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = a_rdy_u;
            step();
        end
        a_valid = 1'b0;
        if (!ok) chk("send_a_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_b(input logic [7:0] d);
        bit ok = 1'b0;
        b_data  = d;
        b_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = b_rdy_u;
            step();
        end
        b_valid = 1'b0;
        if (!ok) chk("send_b_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        fork
            send_a(a);
            send_b(b);
        join
    endtask

    // Returns at the negedge where the sum is first seen valid.
    task automatic wait_out();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = m_vld_u;
        end
        chk("out_seen", 32'(seen), 32'd1);
    endtask

    int  rx_beats = 0;
    bit  rx_v;

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
        a_data = 8'h00; b_data = 8'h00;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 32'(m_vld_u), 32'd0);
            chk("rst_data", 32'(m_dat_u), 32'h0000);
            chk("rst_count", 32'(cnt_u), 32'd0);
            chk("rst_a_ready", 32'(a_rdy_u), 32'd0);
            chk("rst_b_ready", 32'(b_rdy_s), 32'd0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", 32'(a_rdy_u), 32'd1);
        chk("post_rst_b_ready", 32'(b_rdy_u), 32'd1);
        step();

        // Same-cycle pair: 0x05 + 0x03.
        send_pair(8'h05, 8'h03);
        @(negedge clk);
        chk("pair_lat_not_yet", 32'(m_vld_u), 32'd0);
        @(negedge clk);
        chk("pair_valid", 32'(m_vld_u), 32'd1);
        chk("pair_sum", 32'(m_dat_u), 32'h0008);
        step();
        @(negedge clk);
        chk("pair_count1", 32'(cnt_u), 32'd1);
        chk("pair_drained", 32'(m_vld_u), 32'd0);
        step();

        // Zero versus sign extension.
        send_pair(8'hFF, 8'hFF);
        wait_out();
        chk("ff_ff_unsigned", 32'(m_dat_u), 32'h01FE);
        chk("ff_ff_signed", 32'(m_dat_s), 32'hFFFE);
        step();
        send_pair(8'h80, 8'hFF);
        wait_out();
        chk("80_ff_unsigned", 32'(m_dat_u), 32'h017F);
        chk("80_ff_signed", 32'(m_dat_s), 32'hFF7F);
        step();

        // Skewed arrival: A held seven cycles before B shows up.
        send_a(8'h10);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("skew_a_ready", 32'(a_rdy_u), 32'd0);
            chk("skew_no_sum", 32'(m_vld_u), 32'd0);
            step();
        end
        send_b(8'h20);
        wait_out();
        chk("skew_sum", 32'(m_dat_u), 32'h0030);
        step();
        @(negedge clk);
        chk("skew_count", 32'(cnt_u), 32'd4);
        step();

        // Stalling receiver: ready drops 20-50 cycles after every beat.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    send_a(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    send_b(8'($urandom));
                end
            end
            begin
                m_ready = 1'b1;
                for (int c = 0; c < 30000 && rx_beats < 200; c++) begin
                    @(negedge clk);
                    rx_v = m_vld_u;
                    step();
                    if (rx_v && m_ready) begin
                        rx_beats++;
                        m_ready = 1'b0;
                        repeat ($urandom_range(20, 50)) @(posedge clk);
                        #2;
                        m_ready = 1'b1;
                    end
                end
            end
        join
        chk("bp_beats", 32'(rx_beats), 32'd200);
        @(negedge clk);
        chk("bp_count", 32'(cnt_u), 32'd204);
        chk("bp_idle", 32'(m_vld_u), 32'd0);
        step();

        // Reset with a pending sum and a lone held A.
        m_ready = 1'b0;
        send_pair(8'h01, 8'h01);
        send_a(8'h55);
        @(negedge clk);
        chk("mid_pending", 32'(m_vld_u), 32'd1);
        chk("mid_held_sum", 32'(m_dat_u), 32'h0002);
        chk("mid_a_full", 32'(a_rdy_u), 32'd0);
        step();
        @(negedge clk);
        chk("mid_stable_sum", 32'(m_dat_u), 32'h0002);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(m_vld_u), 32'd0);
        chk("mid_rst_a_ready", 32'(a_rdy_u), 32'd1);
        chk("mid_rst_b_ready", 32'(b_rdy_u), 32'd1);
        chk("mid_rst_count", 32'(cnt_u), 32'd0);
        step();
        m_ready = 1'b1;
        send_pair(8'h01, 8'h02);
        wait_out();
        chk("post_rst_sum", 32'(m_dat_u), 32'h0003);
        step();
        @(negedge clk);
        chk("post_rst_count", 32'(cnt_u), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
